// File: rtl/layer0_pkg.sv
// Shared types and constants for the layer-0 input quantizer.
package layer0_pkg;

    // Collector states: gathering beats, or holding a finished frame for the output.
    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Width of the optional clipped-beat counter.
    localparam int unsigned CLIP_CNT_W = 16;

    // Largest code representable in q_bits bits.
    function automatic int unsigned maxc(input int unsigned q_bits);
        return (32'd1 << q_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/layer0_quant_cell.sv
// Combinational quantizer: subtract a bias, shift right, clip to [0, MAXC].
module layer0_quant_cell
    import layer0_pkg::*;
#(
    parameter int unsigned             IN_W   = 16,
    parameter int unsigned             Q_BITS = 2,
    parameter logic signed [IN_W-1:0]  OFFSET = '0,
    parameter int unsigned             SHIFT  = 8
) (
    input  logic [IN_W-1:0]   s_data,
    output logic [Q_BITS-1:0] code,
    output logic              clipped
);

    localparam logic [IN_W:0]     MaxcExt  = (IN_W + 1)'(maxc(Q_BITS));
    localparam logic [Q_BITS-1:0] MaxcCode = Q_BITS'(maxc(Q_BITS));

    // One extra bit so the subtraction can never wrap.
    logic [IN_W:0] d;
    logic [IN_W:0] q;

    assign d = {s_data[IN_W-1], s_data} - {OFFSET[IN_W-1], OFFSET};

    // Negative differences clip to zero, oversized quotients clip to MAXC.
    always_comb begin
        q       = '0;
        code    = '0;
        clipped = 1'b0;
        if (d[IN_W]) begin
            clipped = 1'b1;
        end else begin
            q = d >> SHIFT;
            if (q > MaxcExt) begin
                code    = MaxcCode;
                clipped = 1'b1;
            end else begin
                code = q[Q_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/layer0_input_quantizer.sv
// Streaming input quantizer and double-buffered frame packer for layer 0.
// Optional feature: define LAYER0_CLIP_CNT_EN to add the clip_cnt counter port.
module layer0_input_quantizer
    import layer0_pkg::*;
#(
    parameter int unsigned             N_FEAT = 8,
    parameter int unsigned             IN_W   = 16,
    parameter int unsigned             Q_BITS = 2,
    parameter logic signed [IN_W-1:0]  OFFSET = '0,
    parameter int unsigned             SHIFT  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_W-1:0]            s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [N_FEAT*Q_BITS-1:0]   m_data,
    output logic                       m_err
`ifdef LAYER0_CLIP_CNT_EN
    ,
    output logic [CLIP_CNT_W-1:0]      clip_cnt
`endif
);

    localparam int unsigned        W       = N_FEAT * Q_BITS;
    localparam int unsigned        IDX_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0]   LastIdx = IDX_W'(N_FEAT - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       acc;
    logic               acc_err;

    logic [Q_BITS-1:0]  code;
    logic               clipped;
    logic               accept;
    logic               last_slot;
    logic               close;
    logic               err;
    logic               out_free;
    logic [W-1:0]       acc_ins;

    layer0_quant_cell #(
        .IN_W   (IN_W),
        .Q_BITS (Q_BITS),
        .OFFSET (OFFSET),
        .SHIFT  (SHIFT)
    ) u_quant (
        .s_data  (s_data),
        .code    (code),
        .clipped (clipped)
    );

    assign s_ready   = (state == COLLECT);
    assign accept    = s_valid && s_ready;
    assign last_slot = (idx == LastIdx);
    assign close     = accept && (s_last || last_slot);
    // Flags both an early s_last and a missing one on the closing beat.
    assign err       = (s_last != last_slot);
    assign out_free  = !m_valid || m_ready;

    // Accumulator with the current beat's code dropped into its slot.
    always_comb begin
        acc_ins = acc;
        acc_ins[idx*Q_BITS +: Q_BITS] = code;
    end

    // Collector FSM with registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= COLLECT;
            idx     <= '0;
            acc     <= '0;
            acc_err <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_err   <= 1'b0;
        end else begin
            // Consumer drains the output unless a new frame loads below.
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        if (close) begin
                            idx <= '0;
                            if (out_free) begin
                                m_data  <= acc_ins;
                                m_err   <= err;
                                m_valid <= 1'b1;
                                acc     <= '0;
                                acc_err <= 1'b0;
                            end else begin
                                // Park the finished frame until the output frees up.
                                acc     <= acc_ins;
                                acc_err <= err;
                                state   <= FULL;
                            end
                        end else begin
                            acc <= acc_ins;
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (m_ready) begin
                        m_data  <= acc;
                        m_err   <= acc_err;
                        m_valid <= 1'b1;
                        acc     <= '0;
                        acc_err <= 1'b0;
                        state   <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

`ifdef LAYER0_CLIP_CNT_EN
    // Saturating count of accepted beats that were clipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_cnt <= '0;
        end else if (accept && clipped && (clip_cnt != '1)) begin
            clip_cnt <= clip_cnt + 1'b1;
        end
    end
`else
    logic unused_clipped;
    assign unused_clipped = clipped;
`endif

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// Self-checking bench for layer0_input_quantizer at default parameters.
module tb_layer0_input_quantizer;

    localparam int N_FEAT = 8;
    localparam int Q_BITS = 2;
    localparam int SHIFT  = 8;
    localparam int OFFSET = 0;
    localparam int MAXC   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_err;
`ifdef LAYER0_CLIP_CNT_EN
    logic [15:0] clip_cnt;
`endif

    layer0_input_quantizer dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_err    (m_err)
`ifdef LAYER0_CLIP_CNT_EN
        ,
        .clip_cnt (clip_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } frame_t;

    int     checks = 0;
    int     errors = 0;
    frame_t exp_q[$];
    int     cur_codes[$];
    int     model_clips = 0;
    bit     rand_ready = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference quantizer using plain integer arithmetic.
    function automatic int ref_code(input logic [15:0] x, output bit clip);
        int d;
        int q;
        d = int'($signed(x)) - OFFSET;
        if (d < 0) begin
            clip = 1;
            return 0;
        end
        q = d / (1 << SHIFT);
        if (q > MAXC) begin
            clip = 1;
            return MAXC;
        end
        clip = 0;
        return q;
    endfunction

    // Frame model: list of codes per frame, packed when the frame closes.
    task automatic model_accept(input logic [15:0] x, input logic last);
        bit          clip;
        int          c;
        int          pos;
        frame_t      f;
        c = ref_code(x, clip);
        if (clip && model_clips < 65535) model_clips++;
        pos = cur_codes.size();
        cur_codes.push_back(c);
        if (last || pos == N_FEAT - 1) begin
            f.data = 16'd0;
            foreach (cur_codes[k]) f.data = f.data + 16'(cur_codes[k] * (1 << (k * Q_BITS)));
            f.err = (last != (pos == N_FEAT - 1));
            exp_q.push_back(f);
            cur_codes.delete();
        end
    endtask

    // Presents one beat, waits (bounded) for acceptance; returns at posedge+1.
    task automatic send_beat(input logic [15:0] x, input logic last);
        bit got;
        int n;
        got = 0;
        n = 0;
        s_valid = 1'b1;
        s_data  = x;
        s_last  = last;
        while (!got && n < 200) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            got = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (got) model_accept(x, last);
        else check("beat_accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("idle_after_drain", 32'(m_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        exp_q.delete();
        cur_codes.delete();
        model_clips = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every transfer must match the next expected frame.
    always @(negedge clk) begin
        frame_t f;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                f = exp_q.pop_front();
                check("frame_data", 32'(m_data), 32'(f.data));
                check("frame_err", 32'(m_err), 32'(f.err));
            end
        end
    end

    initial begin
        logic [15:0] qpts [5];
        logic [15:0] x;
        int          len;
        bit          nolast;

        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        m_ready = 1'b1;
        #2;
        check("async_rst_s_ready", 32'(s_ready), 32'd1);
        do_reset();

        // Quantizer points as one early-closed frame of five beats.
        qpts[0] = 16'h0000; qpts[1] = 16'h0100; qpts[2] = 16'h02FF;
        qpts[3] = 16'h0400; qpts[4] = 16'hFF00;
        for (int i = 0; i < 5; i++) send_beat(qpts[i], 1'(i == 4));
        drain();
`ifdef LAYER0_CLIP_CNT_EN
        check("clip_cnt_points", 32'(clip_cnt), 32'd2);
`endif

        // Full frame, and one-edge latency to m_valid.
        for (int i = 0; i < 8; i++) send_beat(16'h0100, 1'(i == 7));
        check("full_latency_m_valid", 32'(m_valid), 32'd1);
        check("full_m_data", 32'(m_data), 32'h5555);
        drain();

        // Early last.
        for (int i = 0; i < 3; i++) send_beat(16'h0300, 1'(i == 2));
        check("early_m_data", 32'(m_data), 32'h003F);
        check("early_m_err", 32'(m_err), 32'd1);
        drain();

        // Missing last, then the ninth beat opens a fresh frame.
        for (int i = 0; i < 8; i++) send_beat(16'h0200, 1'b0);
        check("missing_m_err", 32'(m_err), 32'd1);
        for (int i = 0; i < 8; i++) send_beat(16'(i * 16'h0100), 1'(i == 7));
        drain();

        // Backpressure across two back-to-back frames.
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            x = 16'($urandom_range(0, 16'h05FF));
            send_beat(x, 1'(i == 7 || i == 15));
        end
        check("bp_s_ready_low", 32'(s_ready), 32'd0);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        @(posedge clk);
        #1;
        check("bp_s_ready_held", 32'(s_ready), 32'd0);
        check("bp_frame1_stable", 32'(m_data), 32'(exp_q[0].data));
        drain();

        // Reset mid-frame discards both the parked output and the partial frame.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(16'h0300, 1'(i == 7));
        for (int i = 0; i < 4; i++) send_beat(16'h0100, 1'b0);
        m_ready = 1'b1;
        do_reset();
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
        for (int i = 0; i < 8; i++) send_beat(16'h0200, 1'(i == 7));
        check("post_rst_m_err", 32'(m_err), 32'd0);
        check("post_rst_m_data", 32'(m_data), 32'hAAAA);
        drain();

        // Randomized frames with random consumer backpressure.
        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            nolast = (len == 8) && ($urandom_range(0, 3) == 0);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) x = 16'($urandom);
                else x = 16'($urandom_range(0, 16'h05FF));
                send_beat(x, 1'((k == len - 1) && !nolast));
            end
        end
        rand_ready = 0;
        drain();
`ifdef LAYER0_CLIP_CNT_EN
        check("clip_cnt_random", 32'(clip_cnt), 32'(model_clips));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer0_input_quantizer.md
# layer0_input_quantizer

Streaming front end for the quantized LogicNets network. It accepts raw signed fixed-point input features one per beat, quantizes each to a `Q_BITS` code with clipping, and packs `N_FEAT` codes into one frame word. That frame word is the parallel input bus feeding the layer-0 neuron LUTs. The packer is double-buffered, so the next frame can be collected while the previous one waits for the downstream consumer.

## Interface
- `N_FEAT`, default 8: features per frame.
- `IN_W`, default 16: raw feature width, signed two's complement.
- `Q_BITS`, default 2: code width per feature. `MAXC` = 2^Q_BITS − 1.
- `OFFSET`, default 0: signed subtracted bias, `IN_W` bits.
- `SHIFT`, default 8: right-shift step size. Valid range is 0..IN_W.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `s_valid`  in  1: raw feature beat valid.
- `s_ready`  out  1: beat accepted when `s_valid && s_ready`.
- `s_data`  in  IN_W: raw signed feature.
- `s_last`  in  1: marks the final feature of a frame.
- `m_valid`  out  1: packed frame valid.
- `m_ready`  in  1: consumer accepts the frame.
- `m_data`  out  N_FEAT*Q_BITS: packed codes. Feature k sits at bits [k*Q_BITS +: Q_BITS]; feature 0 is the first beat.
- `m_err`  out  1: frame-length error for the frame currently on `m_data`.
- `clip_cnt`  out  16: present only with `LAYER0_CLIP_CNT_EN`.

## Operation
- **Quantization (combinational, per beat):**
  - `d = s_data − OFFSET`, computed at IN_W+1 bits signed.
  - If `d < 0`: code = 0, and the beat counts as clipped.
  - Else `q = d >> SHIFT`. If `q > MAXC`: code = MAXC (clipped); otherwise code = q[Q_BITS-1:0].
- **Collector state machine:** states `COLLECT` and `FULL`. It holds `idx` (0..N_FEAT−1), the accumulator `acc` and the flag `acc_err`.
  - In `COLLECT`, `s_ready = 1`. Each accepted beat writes its code into `acc` at slot `idx`.
  - A beat closes the frame when `s_last = 1` or `idx = N_FEAT−1`.
  - Error rule for the closing beat: `err = (s_last ≠ (idx == N_FEAT−1))`. This covers both an early `s_last` and a missing one.
  - On an early close, slots above `idx` are zero.
  - After the close, the next accepted beat starts a new frame at `idx = 0`.
- **Frame close handling:**
  - If the output register is free this cycle (`!m_valid || m_ready`): the completed word (acc plus current code) and `err` load into `m_data`/`m_err`, `m_valid` goes to 1, and the collector stays in `COLLECT` with `idx = 0`.
  - Otherwise: the word and error are held in `acc`/`acc_err`, and the state moves to `FULL` (`s_ready = 0`).
- **`FULL`:** when `m_ready` is high, the held word loads into the output register, `m_valid` stays 1, and the state returns to `COLLECT`.
- **Output register:** `m_valid` clears on `m_ready` when no new frame is loading. `m_data` and `m_err` stay stable while `m_valid && !m_ready`.
- **Reset values:** `m_valid = 0`, `m_data = 0`, `m_err = 0`, state `COLLECT`, `idx = 0`, `acc = 0`, `clip_cnt = 0`. As a consequence, `s_ready` is 1 during and after reset.
- **Reset mid-frame:** the partial frame and the output frame are discarded, with no `m_valid` pulse.

## Timing
- Latency: the closing beat is accepted at edge t, and `m_valid` is 1 after edge t.
- Sustained throughput is one beat per cycle when `m_ready` is held high; no bubbles are inserted.
- Frame close and output accept in the same cycle: the new frame replaces the old one; `m_valid` stays 1.
- Backpressure: at most one completed frame is buffered in `acc`. `s_ready` drops on the cycle after a close that could not load the output register.

## Configuration
- With `LAYER0_CLIP_CNT_EN`: the `clip_cnt` port exists. It is a 16-bit saturating counter that increments by 1 per accepted clipped beat, holds at 0xFFFF, and resets to 0.
- Without it: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `layer0_pkg` holds:
  - the state enum (`COLLECT`, `FULL`);
  - the `clip_cnt` width constant (16);
  - a function that computes `MAXC` from `Q_BITS`.
- Sub-module `layer0_quant_cell`: the combinational quantizer. Inputs are `s_data` plus the parameters; outputs are `code` and `clipped`. It is instantiated once.
- The top level contains the collector state machine, `acc`, the output register and the optional counter.

## Test plan
All scenarios use the defaults (N_FEAT 8, Q_BITS 2, OFFSET 0, SHIFT 8).
- **Quantizer points:** inputs 0x0000, 0x0100, 0x02FF, 0x0400, 0xFF00 → codes 0, 1, 2, 3, 0. `clip_cnt` reaches 2 (last two beats).
- **Full frame:** 8 beats with `m_ready = 1`, values 0x0100×8 and `s_last` on beat 7 → `m_data = 0x5555`, `m_err = 0`, `m_valid` one cycle after beat 7.
- **Early last:** 3 beats of 0x0300 with `s_last` on beat 2 → `m_data = 0x003F`, `m_err = 1`.
- **Missing last:** 8 beats with `s_last = 0` → frame emitted with `m_err = 1`; the 9th beat starts a new frame at slot 0.
- **Backpressure:** `m_ready = 0` across two back-to-back frames → second frame held; `s_ready = 0` on the cycle after beat 15. Raising `m_ready` delivers frame 1, then frame 2, with no loss.
- **Reset mid-frame:** assert `rst` after 4 beats → `m_valid = 0`. The next 8 beats form a clean frame with `m_err = 0`.
